song_sequencer: RTL and testbench

//  Parametrised song reader. Walks one external song ROM, decodes note and rest words, and hands notes
//  to note_player over a new_note/note_ack handshake. Adds over the current reader: configurable

---
 rtl/song_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_song_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// Song sequencer: walks one song in an external ROM, decodes note/rest/end words and
// hands notes to the note player over a new_note/note_ack handshake. Supports loop mode,
// song-change/restart rewind and pause that keeps position and remaining rest beats.
module song_sequencer #(
  parameter int unsigned SONG_W  = 2,
  parameter int unsigned NADDR_W = 5,
  parameter int unsigned NOTE_W  = 6,
  parameter int unsigned DUR_W   = 6,
  parameter int unsigned META_W  = 3,
  parameter int unsigned ROM_LAT = 1,
  localparam int unsigned WordW  = 1 + NOTE_W + DUR_W + META_W
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      play_i,
  input  logic                      loop_i,
  input  logic                      restart_i,
  input  logic [SONG_W-1:0]         song_i,
  input  logic                      beat_i,
  output logic [SONG_W+NADDR_W-1:0] rom_addr_o,
  input  logic [WordW-1:0]          rom_data_i,
  output logic                      new_note_o,
  input  logic                      note_ack_i,
  output logic [NOTE_W-1:0]         note_o,
  output logic [DUR_W-1:0]          duration_o,
  output logic [META_W-1:0]         metadata_o,
  output logic                      song_done_o,
  output logic                      busy_o
);

  localparam int unsigned LatW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [LatW-1:0] LatLast = LatW'(ROM_LAT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StNoteOut,
    StRest,
    StAdvance,
    StDone
  } state_e;

  state_e              state_q;
  logic [SONG_W-1:0]   song_q;
  logic [NADDR_W-1:0]  idx_q;
  logic [NOTE_W-1:0]   rest_q;
  logic [LatW-1:0]     lat_q;
  logic [NOTE_W-1:0]   note_q;
  logic [DUR_W-1:0]    dur_q;
  logic [META_W-1:0]   meta_q;
  logic                new_note_q;
  logic                song_done_q;

  // ROM word fields: {is_rest, note, dur, meta}
  logic                word_is_rest;
  logic [NOTE_W-1:0]   word_note;
  logic [DUR_W-1:0]    word_dur;
  logic [META_W-1:0]   word_meta;
  logic                word_is_end;
  logic                rewind;

  assign word_is_rest = rom_data_i[WordW-1];
  assign word_note    = rom_data_i[WordW-2 -: NOTE_W];
  assign word_dur     = rom_data_i[DUR_W+META_W-1 -: DUR_W];
  assign word_meta    = rom_data_i[META_W-1:0];
  // End marker: a note word with zero duration
  assign word_is_end  = !word_is_rest && (word_dur == '0);

  // Restart or a new song selection rewinds the sequencer
  assign rewind = restart_i || (song_i != song_q);

  assign rom_addr_o  = {song_q, idx_q};
  assign new_note_o  = new_note_q;
  assign note_o      = note_q;
  assign duration_o  = dur_q;
  assign metadata_o  = meta_q;
  assign song_done_o = song_done_q;
  assign busy_o      = (state_q != StIdle) && (state_q != StDone);

  // Sequencer FSM with its datapath and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      song_q      <= '0;
      idx_q       <= '0;
      rest_q      <= '0;
      lat_q       <= '0;
      note_q      <= '0;
      dur_q       <= '0;
      meta_q      <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      song_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (play_i) begin
            song_q  <= song_i;
            idx_q   <= '0;
            lat_q   <= '0;
            state_q <= StFetch;
          end
        end

        StDone: begin
          if (rewind) begin
            song_q  <= song_i;
            idx_q   <= '0;
            lat_q   <= '0;
            rest_q  <= '0;
            state_q <= StFetch;
          end
        end

        default: begin
          if (rewind) begin
            // Rewind wins over pause, ack and beat; no song_done pulse
            new_note_q <= 1'b0;
            rest_q     <= '0;
            idx_q      <= '0;
            lat_q      <= '0;
            song_q     <= song_i;
            state_q    <= StFetch;
          end else begin
            unique case (state_q)
              StFetch: begin
                if (play_i) begin
                  if (lat_q == LatLast) begin
                    lat_q   <= '0;
                    state_q <= StDecode;
                  end else begin
                    lat_q <= lat_q + LatW'(1);
                  end
                end
              end

              StDecode: begin
                if (play_i) begin
                  if (word_is_end) begin
                    song_done_q <= 1'b1;
                    if (loop_i) begin
                      idx_q   <= '0;
                      lat_q   <= '0;
                      state_q <= StFetch;
                    end else begin
                      state_q <= StDone;
                    end
                  end else if (word_is_rest) begin
                    rest_q  <= word_note;
                    state_q <= (word_note == '0) ? StAdvance : StRest;
                  end else begin
                    note_q     <= word_note;
                    dur_q      <= word_dur;
                    meta_q     <= word_meta;
                    new_note_q <= 1'b1;
                    state_q    <= StNoteOut;
                  end
                end
              end

              // The handshake completes even while paused
              StNoteOut: begin
                if (note_ack_i) begin
                  new_note_q <= 1'b0;
                  state_q    <= StAdvance;
                end
              end

              StRest: begin
                if (play_i && beat_i) begin
                  if (rest_q <= NOTE_W'(1)) begin
                    rest_q  <= '0;
                    state_q <= StAdvance;
                  end else begin
                    rest_q <= rest_q - NOTE_W'(1);
                  end
                end
              end

              StAdvance: begin
                if (play_i) begin
                  if (idx_q == '1) begin
                    // Last word of the song area: end of song instead of wrapping
                    song_done_q <= 1'b1;
                    if (loop_i) begin
                      idx_q   <= '0;
                      lat_q   <= '0;
                      state_q <= StFetch;
                    end else begin
                      state_q <= StDone;
                    end
                  end else begin
                    idx_q   <= idx_q + NADDR_W'(1);
                    lat_q   <= '0;
                    state_q <= StFetch;
                  end
                end
              end

              default: begin
                state_q <= StIdle;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: expected notes are queued by the stimulus and
// popped by a monitor on each new_note/note_ack handshake.
module tb_song_sequencer;

  localparam int unsigned SongW  = 2;
  localparam int unsigned NaddrW = 5;
  localparam int unsigned RomLat = 2;
  localparam int unsigned W      = 16;
  localparam int unsigned AW     = SongW + NaddrW;

  logic          clk;
  logic          rst_n;
  logic          play;
  logic          loop_en;
  logic          restart;
  logic [1:0]    song;
  logic          beat;
  logic [AW-1:0] rom_addr;
  logic [W-1:0]  rom_data;
  logic          new_note;
  logic          note_ack;
  logic [5:0]    note;
  logic [5:0]    duration;
  logic [2:0]    metadata;
  logic          song_done;
  logic          busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;
  int notes_seen = 0;
  int ack_delay = 3;
  int ack_cnt = 0;
  bit ack_en = 1'b1;
  logic [14:0] exp_q[$];

  logic [W-1:0] rom [2**AW];
  logic [W-1:0] pipe [RomLat];

  song_sequencer #(
    .SONG_W (SongW),
    .NADDR_W(NaddrW),
    .NOTE_W (6),
    .DUR_W  (6),
    .META_W (3),
    .ROM_LAT(RomLat)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .play_i     (play),
    .loop_i     (loop_en),
    .restart_i  (restart),
    .song_i     (song),
    .beat_i     (beat),
    .rom_addr_o (rom_addr),
    .rom_data_i (rom_data),
    .new_note_o (new_note),
    .note_ack_i (note_ack),
    .note_o     (note),
    .duration_o (duration),
    .metadata_o (metadata),
    .song_done_o(song_done),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM with RomLat cycles of read latency
  always @(posedge clk) begin
    pipe[0] <= rom[rom_addr];
    for (int i = 1; i < RomLat; i++) pipe[i] <= pipe[i-1];
  end
  assign rom_data = pipe[RomLat-1];

  function automatic logic [W-1:0] mk_note(input int n, input int d, input int m);
    return {1'b0, 6'(n), 6'(d), 3'(m)};
  endfunction

  function automatic logic [W-1:0] mk_rest(input int n);
    return {1'b1, 6'(n), 6'd0, 3'd0};
  endfunction

  function automatic logic [14:0] fld(input int n, input int d, input int m);
    return {6'(n), 6'(d), 3'(m)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Note player: acks ack_delay cycles after new_note rises
  initial begin
    note_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (new_note && !note_ack && ack_en) begin
        if (ack_cnt >= ack_delay) begin
          note_ack = 1'b1;
          ack_cnt  = 0;
        end else begin
          ack_cnt++;
        end
      end else begin
        note_ack = 1'b0;
        if (!new_note) ack_cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake and counts song_done pulses
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && song_done) done_cnt++;
      if (rst_n && new_note && note_ack) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_note: got note %0d dur %0d expected none", note, duration);
        end else begin
          check("note_fields", 32'({note, duration, metadata}), 32'(exp_q.pop_front()));
          notes_seen++;
        end
      end
    end
  end

  task automatic do_reset();
    rst_n   = 1'b0;
    play    = 1'b0;
    loop_en = 1'b0;
    restart = 1'b0;
    beat    = 1'b0;
    song    = 2'd0;
    ack_en  = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    done_cnt   = 0;
    notes_seen = 0;
    rst_n      = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(input int n, input int budget, input string name);
    int cyc = 0;
    while (done_cnt < n && cyc < budget) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    check(name, 32'(done_cnt >= n), 32'd1);
  endtask

  task automatic wait_addr(input logic [AW-1:0] a, input int budget, input string name);
    int cyc = 0;
    while (rom_addr !== a && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check(name, 32'(rom_addr), 32'(a));
  endtask

  task automatic wait_new_note(input int budget, input string name);
    int cyc = 0;
    while (new_note !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check(name, 32'(new_note), 32'd1);
  endtask

  task automatic give_beat();
    @(negedge clk);
    beat = 1'b1;
    @(negedge clk);
    beat = 1'b0;
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 2**AW; i++) rom[i] = '0;
    // Song 0: note, rest 5, note, end
    rom[0]  = mk_note(7, 3, 5);
    rom[1]  = mk_rest(5);
    rom[2]  = mk_note(9, 2, 0);
    // Song 1: two notes then end
    rom[32] = mk_note(12, 8, 1);
    rom[33] = mk_note(20, 4, 2);
    // Song 2: A, B, end
    rom[64] = mk_note(30, 10, 3);
    rom[65] = mk_note(31, 11, 4);
    // Song 3: 32 notes, no end marker
    for (int i = 0; i < 32; i++) rom[96+i] = mk_note(i + 1, i + 1, i % 8);
    for (int i = 0; i < RomLat; i++) pipe[i] = '0;

    rst_n = 1'b0; play = 1'b0; loop_en = 1'b0; restart = 1'b0; beat = 1'b0; song = 2'd0;
    repeat (2) @(negedge clk);
    check("reset_new_note", 32'(new_note), 32'd0);
    check("reset_rom_addr", 32'(rom_addr), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_song_done", 32'(song_done), 32'd0);
    check("reset_fields", 32'({note, duration, metadata}), 32'd0);

    // Two-note song, ack 3 cycles after each new_note, then DONE
    do_reset();
    check("idle_busy", 32'(busy), 32'd0);
    exp_q.push_back(fld(12, 8, 1));
    exp_q.push_back(fld(20, 4, 2));
    song = 2'd1;
    play = 1'b1;
    wait_done(1, 200, "t1_done_seen");
    check("t1_notes", 32'(notes_seen), 32'd2);
    @(negedge clk);
    check("t1_done_pulse_len", 32'(song_done), 32'd0);
    check("t1_busy_done", 32'(busy), 32'd0);
    check("t1_new_note_low", 32'(new_note), 32'd0);
    repeat (10) @(negedge clk);
    check("t1_done_holds", 32'(busy), 32'd0);
    check("t1_single_done", 32'(done_cnt), 32'd1);
    // Restart from DONE replays the song
    exp_q.push_back(fld(12, 8, 1));
    exp_q.push_back(fld(20, 4, 2));
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("t1_restart_busy", 32'(busy), 32'd1);
    check("t1_restart_addr", 32'(rom_addr), 32'd32);
    wait_done(2, 200, "t1_restart_done");
    check("t1_restart_notes", 32'(notes_seen), 32'd4);

    // Rest of 5 beats with a pause after 2 beats
    do_reset();
    exp_q.push_back(fld(7, 3, 5));
    play = 1'b1;
    wait_addr(7'd1, 100, "t2_reach_rest_word");
    repeat (4) @(negedge clk);
    give_beat();
    give_beat();
    play = 1'b0;
    repeat (10) give_beat();
    repeat (3) @(negedge clk);
    check("t2_paused_addr", 32'(rom_addr), 32'd1);
    check("t2_paused_busy", 32'(busy), 32'd1);
    play = 1'b1;
    give_beat();
    give_beat();
    repeat (3) @(negedge clk);
    check("t2_four_beats_addr", 32'(rom_addr), 32'd1);
    check("t2_rest_quiet", 32'(new_note), 32'd0);
    exp_q.push_back(fld(9, 2, 0));
    give_beat();
    @(negedge clk);
    check("t2_fifth_beat_addr", 32'(rom_addr), 32'd2);
    wait_done(1, 200, "t2_done_seen");
    check("t2_notes", 32'(notes_seen), 32'd2);

    // Loop mode: A,B,A,B,A,B with one song_done per pass
    do_reset();
    for (int p = 0; p < 3; p++) begin
      exp_q.push_back(fld(30, 10, 3));
      exp_q.push_back(fld(31, 11, 4));
    end
    loop_en = 1'b1;
    song    = 2'd2;
    play    = 1'b1;
    wait_done(1, 200, "t3_pass1");
    check("t3_pass1_notes", 32'(notes_seen), 32'd2);
    wait_done(3, 400, "t3_pass3");
    play = 1'b0;
    check("t3_pass3_notes", 32'(notes_seen), 32'd6);
    repeat (5) @(negedge clk);
    check("t3_rewound_addr", 32'(rom_addr), 32'd64);
    check("t3_loop_busy", 32'(busy), 32'd1);
    check("t3_done_count", 32'(done_cnt), 32'd3);

    // Song change 0 -> 2 while a note is waiting for ack
    do_reset();
    ack_en = 1'b0;
    play   = 1'b1;
    wait_new_note(100, "t4_note_out");
    check("t4_addr_before", 32'(rom_addr), 32'd0);
    repeat (2) @(negedge clk);
    song = 2'd2;
    @(negedge clk);
    check("t4_new_note_drop", 32'(new_note), 32'd0);
    check("t4_addr_after", 32'(rom_addr), 32'd64);
    repeat (2) @(negedge clk);
    check("t4_no_done", 32'(done_cnt), 32'd0);
    exp_q.push_back(fld(30, 10, 3));
    exp_q.push_back(fld(31, 11, 4));
    ack_en = 1'b1;
    wait_done(1, 200, "t4_done_seen");
    check("t4_notes", 32'(notes_seen), 32'd2);

    // Full 32-word song, ack in the same cycle new_note rises
    do_reset();
    ack_delay = 0;
    for (int i = 0; i < 32; i++) exp_q.push_back(fld(i + 1, i + 1, i % 8));
    song = 2'd3;
    play = 1'b1;
    bad  = 0;
    for (int c = 0; c < 1000 && done_cnt == 0; c++) begin
      @(negedge clk);
      #2;
      if (rom_addr[6:5] != 2'd3) bad++;
    end
    check("t5_done_seen", 32'(done_cnt), 32'd1);
    check("t5_addr_in_song", 32'(bad), 32'd0);
    check("t5_notes", 32'(notes_seen), 32'd32);
    @(negedge clk);
    check("t5_busy_done", 32'(busy), 32'd0);
    ack_delay = 3;

    // Asynchronous reset in the middle of a rest
    do_reset();
    exp_q.push_back(fld(7, 3, 5));
    play = 1'b1;
    wait_addr(7'd1, 100, "t6_reach_rest_word");
    repeat (4) @(negedge clk);
    give_beat();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_addr", 32'(rom_addr), 32'd0);
    check("t6_rst_fields", 32'({new_note, song_done, note, duration, metadata}), 32'd0);
    play = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_idle_busy", 32'(busy), 32'd0);
    exp_q.push_back(fld(7, 3, 5));
    play = 1'b1;
    @(negedge clk);
    check("t6_run_busy", 32'(busy), 32'd1);
    repeat (15) @(negedge clk);
    check("t6_replayed", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
